// File: rtl/hybrid_branch_predictor_pkg.sv
// Shared types, sizes and index helpers for the hybrid branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hybrid_branch_predictor_pkg;

  localparam int N             = 4;
  localparam int CTR_BITS      = 2;
  localparam int LHIST_BITS    = 4;
  localparam int LBHT_IDX_BITS = 5;
  localparam int GHIST_BITS    = 6;
  localparam int GPHT_IDX_BITS = 8;
  localparam int CHS_IDX_BITS  = 8;
  localparam int BTB_IDX_BITS  = 5;

  localparam int LPHT_DEPTH   = 1 << LHIST_BITS;
  localparam int LBHT_DEPTH   = 1 << LBHT_IDX_BITS;
  localparam int GPHT_DEPTH   = 1 << GPHT_IDX_BITS;
  localparam int CHS_DEPTH    = 1 << CHS_IDX_BITS;
  localparam int BTB_DEPTH    = 1 << BTB_IDX_BITS;
  localparam int BTB_TAG_BITS = 32 - BTB_IDX_BITS - 2;

  // Weakly not-taken (01..1) and weakly prefer-local (10..0).
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT    = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_LOCAL = {1'b1, {(CTR_BITS-1){1'b0}}};

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] pc;
  } pc_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } rob_entry_t;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
  } btb_entry_t;

  typedef rob_entry_t [N-1:0] rob_if_packet_t;
  typedef pc_entry_t  [N-1:0] target_pc_t;

  function automatic logic [LBHT_IDX_BITS-1:0] lbht_index(input logic [31:0] pc);
    return pc[LBHT_IDX_BITS+1:2];
  endfunction

  function automatic logic [CHS_IDX_BITS-1:0] chs_index(input logic [31:0] pc);
    return pc[CHS_IDX_BITS+1:2];
  endfunction

  function automatic logic [BTB_IDX_BITS-1:0] btb_index(input logic [31:0] pc);
    return pc[BTB_IDX_BITS+1:2];
  endfunction

  function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [31:0] pc);
    return pc[31:BTB_IDX_BITS+2];
  endfunction

  // History occupies the MSBs of the index so short histories still spread the table.
  function automatic logic [GPHT_IDX_BITS-1:0] gshare_index(input logic [31:0]           pc,
                                                            input logic [GHIST_BITS-1:0] ghr);
    logic [GPHT_IDX_BITS-1:0] hpad;
    hpad = '0;
    hpad[GPHT_IDX_BITS-1 -: GHIST_BITS] = ghr;
    return pc[GPHT_IDX_BITS+1:2] ^ hpad;
  endfunction

endpackage

// File: rtl/hybrid_branch_predictor_if.sv
// Fetch/ROB side bundle of the branch predictor: fetch PC in, per-slot predictions out.
// Latency: predictions combinational from pc_start; retire/squash/fire take effect next edge.
// Backpressure: none; fetch_fire qualifies the bundle, the predictor never stalls.
interface hybrid_branch_predictor_if;
  import hybrid_branch_predictor_pkg::*;

  logic [31:0]    pc_start;
  logic           fetch_fire;
  logic           squash;
  rob_if_packet_t rob_if_packet;
  target_pc_t     target_pc;

  modport master (
    output pc_start, fetch_fire, squash, rob_if_packet,
    input  target_pc
  );

  modport slave (
    input  pc_start, fetch_fire, squash, rob_if_packet,
    output target_pc
  );
endinterface

// File: rtl/hybrid_branch_predictor_sat_counter_table.sv
// Table of saturating counters with chained update ports; whole state exported for reads.
// Latency: reads reflect registered state; updates visible one cycle later.
// Backpressure: none; all update ports are accepted every cycle.
module hybrid_branch_predictor_sat_counter_table #(
  parameter int                  IDX_BITS  = 8,
  parameter int                  CTR_BITS  = 2,
  parameter int                  PORTS     = 4,
  parameter logic [CTR_BITS-1:0] RESET_VAL = '0
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [PORTS-1:0]                            upd_en,
  input  logic [PORTS-1:0][IDX_BITS-1:0]              upd_idx,
  input  logic [PORTS-1:0]                            upd_inc,
  output logic [(1<<IDX_BITS)-1:0][CTR_BITS-1:0]      ctr
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [DEPTH-1:0][CTR_BITS-1:0] ctr_q;
  logic [DEPTH-1:0][CTR_BITS-1:0] ctr_nxt;

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] v,
                                                   input logic                inc);
    if (inc) return (&v) ? v : v + 1'b1;
    return (|v) ? v - 1'b1 : v;
  endfunction

  assign ctr = ctr_q;

  // Apply ports in order so a later port builds on an earlier port's result for the same entry.
  always_comb begin
    ctr_nxt = ctr_q;
    for (int i = 0; i < PORTS; i++) begin
      if (upd_en[i]) ctr_nxt[upd_idx[i]] = sat_step(ctr_nxt[upd_idx[i]], upd_inc[i]);
    end
  end

  // Counter storage with synchronous reset to the configured weak value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) ctr_q[d] <= RESET_VAL;
    end else begin
      ctr_q <= ctr_nxt;
    end
  end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// Hybrid local/gshare direction predictor with chooser and BTB, N slots per fetch bundle.
// Latency: prediction combinational (0 cycles); training and GHR updates visible next cycle.
// Backpressure: none; fetch_fire only advances speculative history, squash overrides it.
module hybrid_branch_predictor
  import hybrid_branch_predictor_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  hybrid_branch_predictor_if.slave bus
);

  logic [LHIST_BITS-1:0] lbht_q   [LBHT_DEPTH];
  logic [LHIST_BITS-1:0] lbht_nxt [LBHT_DEPTH];
  btb_entry_t            btb_q    [BTB_DEPTH];
  btb_entry_t            btb_nxt  [BTB_DEPTH];

  logic [GHIST_BITS-1:0] spec_ghr_q;
  logic [GHIST_BITS-1:0] commit_ghr_q;
  logic [GHIST_BITS-1:0] commit_ghr_nxt;
  logic [GHIST_BITS-1:0] fire_ghr;

  logic [LPHT_DEPTH-1:0][CTR_BITS-1:0] lpht_ctr;
  logic [GPHT_DEPTH-1:0][CTR_BITS-1:0] gpht_ctr;
  logic [CHS_DEPTH-1:0][CTR_BITS-1:0]  chs_ctr;

  logic [N-1:0]                    lpht_en, lpht_inc;
  logic [N-1:0]                    gpht_en, gpht_inc;
  logic [N-1:0]                    chs_en,  chs_inc;
  logic [N-1:0][LHIST_BITS-1:0]    lpht_idx;
  logic [N-1:0][GPHT_IDX_BITS-1:0] gpht_idx;
  logic [N-1:0][CHS_IDX_BITS-1:0]  chs_idx;

  target_pc_t pred;

  hybrid_branch_predictor_sat_counter_table #(
    .IDX_BITS(LHIST_BITS), .CTR_BITS(CTR_BITS), .PORTS(N), .RESET_VAL(CTR_WEAK_NT)
  ) u_local_pht (
    .clock(clock), .reset(reset),
    .upd_en(lpht_en), .upd_idx(lpht_idx), .upd_inc(lpht_inc), .ctr(lpht_ctr)
  );

  hybrid_branch_predictor_sat_counter_table #(
    .IDX_BITS(GPHT_IDX_BITS), .CTR_BITS(CTR_BITS), .PORTS(N), .RESET_VAL(CTR_WEAK_NT)
  ) u_gshare_pht (
    .clock(clock), .reset(reset),
    .upd_en(gpht_en), .upd_idx(gpht_idx), .upd_inc(gpht_inc), .ctr(gpht_ctr)
  );

  hybrid_branch_predictor_sat_counter_table #(
    .IDX_BITS(CHS_IDX_BITS), .CTR_BITS(CTR_BITS), .PORTS(N), .RESET_VAL(CTR_WEAK_LOCAL)
  ) u_chooser (
    .clock(clock), .reset(reset),
    .upd_en(chs_en), .upd_idx(chs_idx), .upd_inc(chs_inc), .ctr(chs_ctr)
  );

  // Walk the bundle slot by slot; each slot sees the history and PC produced by earlier slots.
  // A slot that predicts not-taken (including a BTB miss) contributes a 0 to the history.
  always_comb begin
    logic [31:0]           p;
    logic [GHIST_BITS-1:0] ghr;
    logic                  ended;
    logic [LHIST_BITS-1:0] hist;
    logic                  dir;
    logic                  hit;
    logic                  tk;
    btb_entry_t            be;
    p     = bus.pc_start;
    ghr   = spec_ghr_q;
    ended = 1'b0;
    hist  = '0;
    dir   = 1'b0;
    hit   = 1'b0;
    tk    = 1'b0;
    be    = '0;
    pred  = '0;
    for (int i = 0; i < N; i++) begin
      hist = lbht_q[lbht_index(p)];
      dir  = chs_ctr[chs_index(p)][CTR_BITS-1] ? lpht_ctr[hist][CTR_BITS-1]
                                               : gpht_ctr[gshare_index(p, ghr)][CTR_BITS-1];
      be   = btb_q[btb_index(p)];
      hit  = be.valid && (be.tag == btb_tag(p));
      tk   = !ended && dir && hit;
      pred[i].valid = !ended;
      pred[i].taken = tk;
      pred[i].pc    = tk ? be.target : p + 32'd4;
      if (!ended) ghr = {ghr[GHIST_BITS-2:0], tk};
      if (tk) ended = 1'b1;
      p = pred[i].pc;
    end
    fire_ghr = ghr;
  end

  assign bus.target_pc = pred;

  // Retire-side training: slots applied in order, each sees the history left by earlier slots;
  // chooser correctness is judged on counter values from before this cycle.
  always_comb begin
    logic [GHIST_BITS-1:0]    ghr;
    logic [LBHT_IDX_BITS-1:0] li;
    logic [LHIST_BITS-1:0]    hist;
    logic [GPHT_IDX_BITS-1:0] gi;
    logic                     l_ok;
    logic                     g_ok;
    rob_entry_t               e;
    lbht_nxt = lbht_q;
    btb_nxt  = btb_q;
    ghr      = commit_ghr_q;
    li       = '0;
    hist     = '0;
    gi       = '0;
    l_ok     = 1'b0;
    g_ok     = 1'b0;
    e        = '0;
    lpht_en  = '0;
    lpht_inc = '0;
    lpht_idx = '0;
    gpht_en  = '0;
    gpht_inc = '0;
    gpht_idx = '0;
    chs_en   = '0;
    chs_inc  = '0;
    chs_idx  = '0;
    for (int i = 0; i < N; i++) begin
      e = bus.rob_if_packet[i];
      if (e.valid) begin
        li   = lbht_index(e.pc);
        hist = lbht_nxt[li];
        gi   = gshare_index(e.pc, ghr);
        l_ok = (lpht_ctr[hist][CTR_BITS-1] == e.taken);
        g_ok = (gpht_ctr[gi][CTR_BITS-1] == e.taken);

        lpht_en[i]  = 1'b1;
        lpht_idx[i] = hist;
        lpht_inc[i] = e.taken;
        gpht_en[i]  = 1'b1;
        gpht_idx[i] = gi;
        gpht_inc[i] = e.taken;
        chs_en[i]   = (l_ok != g_ok);
        chs_idx[i]  = chs_index(e.pc);
        chs_inc[i]  = l_ok;

        lbht_nxt[li] = {hist[LHIST_BITS-2:0], e.taken};
        ghr          = {ghr[GHIST_BITS-2:0], e.taken};
        if (e.taken) begin
          btb_nxt[btb_index(e.pc)] = '{valid: 1'b1, tag: btb_tag(e.pc), target: e.target};
        end
      end
    end
    commit_ghr_nxt = ghr;
  end

  // History tables, BTB and both GHRs; squash repairs speculative history from the commit side.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < LBHT_DEPTH; d++) lbht_q[d] <= '0;
      for (int d = 0; d < BTB_DEPTH; d++)  btb_q[d]  <= '0;
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
    end else begin
      lbht_q       <= lbht_nxt;
      btb_q        <= btb_nxt;
      commit_ghr_q <= commit_ghr_nxt;
      if (bus.squash)          spec_ghr_q <= commit_ghr_nxt;
      else if (bus.fetch_fire) spec_ghr_q <= fire_ghr;
    end
  end

endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Randomised and directed bench for the hybrid branch predictor against an in-bench model.
// Latency: checks outputs once per cycle on the falling edge.
// Backpressure: n/a.
module tb_hybrid_branch_predictor;
  import hybrid_branch_predictor_pkg::*;

  logic clock;
  logic reset;

  hybrid_branch_predictor_if bus ();

  hybrid_branch_predictor dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain integer tables.
  int          m_lpht [LPHT_DEPTH];
  int          m_gpht [GPHT_DEPTH];
  int          m_chs  [CHS_DEPTH];
  int          m_lbht [LBHT_DEPTH];
  bit          m_btb_v   [BTB_DEPTH];
  int unsigned m_btb_tag [BTB_DEPTH];
  int unsigned m_btb_tgt [BTB_DEPTH];
  int          m_spec_ghr;
  int          m_commit_ghr;

  bit          e_valid [N];
  bit          e_taken [N];
  int unsigned e_pc    [N];
  int          e_fire_ghr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << CTR_BITS) - 1) return (1 << CTR_BITS) - 1;
    return v;
  endfunction

  task automatic model_reset();
    foreach (m_lpht[k]) m_lpht[k] = 1;
    foreach (m_gpht[k]) m_gpht[k] = 1;
    foreach (m_chs[k])  m_chs[k]  = 2;
    foreach (m_lbht[k]) m_lbht[k] = 0;
    foreach (m_btb_v[k]) begin
      m_btb_v[k] = 0; m_btb_tag[k] = 0; m_btb_tgt[k] = 0;
    end
    m_spec_ghr = 0;
    m_commit_ghr = 0;
  endtask

  // Expected per-slot outputs from the current model state and pc_start.
  task automatic model_predict();
    int unsigned p;
    int g, bi, h;
    bit ended, dl, dg, dir, hit, tk;
    p = bus.pc_start;
    g = m_spec_ghr;
    ended = 0;
    for (int i = 0; i < N; i++) begin
      h   = m_lbht[(p >> 2) % LBHT_DEPTH];
      dl  = m_lpht[h] >= 2;
      dg  = m_gpht[((p >> 2) % GPHT_DEPTH) ^ (g << 2)] >= 2;
      dir = (m_chs[(p >> 2) % CHS_DEPTH] >= 2) ? dl : dg;
      bi  = (p >> 2) % BTB_DEPTH;
      hit = m_btb_v[bi] && (m_btb_tag[bi] == (p >> 7));
      tk  = !ended && dir && hit;
      e_valid[i] = !ended;
      e_taken[i] = tk;
      e_pc[i]    = tk ? m_btb_tgt[bi] : p + 4;
      if (!ended) g = ((g << 1) | int'(tk)) % 64;
      if (tk) ended = 1;
      p = e_pc[i];
    end
    e_fire_ghr = g;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_update();
    int lp0 [LPHT_DEPTH];
    int gp0 [GPHT_DEPTH];
    int cg, li, h, gi, ci, bi;
    int unsigned pc;
    bit t, lok, gok;
    if (reset) begin
      model_reset();
      return;
    end
    lp0 = m_lpht;
    gp0 = m_gpht;
    cg  = m_commit_ghr;
    for (int i = 0; i < N; i++) begin
      if (bus.rob_if_packet[i].valid) begin
        pc  = bus.rob_if_packet[i].pc;
        t   = bus.rob_if_packet[i].taken;
        li  = (pc >> 2) % LBHT_DEPTH;
        h   = m_lbht[li];
        gi  = ((pc >> 2) % GPHT_DEPTH) ^ (cg << 2);
        ci  = (pc >> 2) % CHS_DEPTH;
        lok = (lp0[h] >= 2) == t;
        gok = (gp0[gi] >= 2) == t;
        m_lpht[h]  = sat(m_lpht[h] + (t ? 1 : -1));
        m_gpht[gi] = sat(m_gpht[gi] + (t ? 1 : -1));
        if (lok && !gok) m_chs[ci] = sat(m_chs[ci] + 1);
        if (gok && !lok) m_chs[ci] = sat(m_chs[ci] - 1);
        m_lbht[li] = ((h << 1) | int'(t)) % LPHT_DEPTH;
        cg = ((cg << 1) | int'(t)) % 64;
        if (t) begin
          bi = (pc >> 2) % BTB_DEPTH;
          m_btb_v[bi]   = 1;
          m_btb_tag[bi] = pc >> 7;
          m_btb_tgt[bi] = bus.rob_if_packet[i].target;
        end
      end
    end
    m_commit_ghr = cg;
    if (bus.squash)          m_spec_ghr = cg;
    else if (bus.fetch_fire) m_spec_ghr = e_fire_ghr;
  endtask

  // One clock: compare all slots on the falling edge, then step the model past the rising edge.
  task automatic cycle();
    @(negedge clock);
    model_predict();
    for (int i = 0; i < N; i++) begin
      check($sformatf("slot%0d valid", i), 32'(bus.target_pc[i].valid), 32'(e_valid[i]));
      check($sformatf("slot%0d taken", i), 32'(bus.target_pc[i].taken), 32'(e_taken[i]));
      check($sformatf("slot%0d pc", i), bus.target_pc[i].pc, e_pc[i]);
    end
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [31:0] pcs);
    reset          = 1'b0;
    bus.pc_start   = pcs;
    bus.fetch_fire = 1'b0;
    bus.squash     = 1'b0;
    bus.rob_if_packet = '0;
  endtask

  task automatic retire1(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    idle(32'h100);
    bus.rob_if_packet[0] = '{valid: 1'b1, pc: pc, taken: t, target: tgt};
    cycle();
  endtask

  task automatic check_fallthrough(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s slot%0d valid", tag, i), 32'(bus.target_pc[i].valid), 32'd1);
      check($sformatf("%s slot%0d taken", tag, i), 32'(bus.target_pc[i].taken), 32'd0);
      check($sformatf("%s slot%0d pc", tag, i), bus.target_pc[i].pc, 32'h104 + 32'(4 * i));
    end
  endtask

  initial begin
    int pre;
    idle(32'h100);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
    #1;

    // Out of reset every slot falls through sequentially.
    check_fallthrough("reset");

    // Four single taken retires walk history 0000 -> 1111, then two same-cycle retires
    // both land on local counter 15 and chain 01 -> 10 -> 11.
    repeat (4) retire1(32'h100, 1'b1, 32'h200);
    idle(32'h100);
    bus.rob_if_packet[0] = '{valid: 1'b1, pc: 32'h100, taken: 1'b1, target: 32'h200};
    bus.rob_if_packet[1] = '{valid: 1'b1, pc: 32'h100, taken: 1'b1, target: 32'h200};
    cycle();
    idle(32'h100);
    #1;
    check("model chained lpht[15]", 32'(m_lpht[15]), 32'd3);
    check("trained slot0 taken", 32'(bus.target_pc[0].taken), 32'd1);
    check("trained slot0 pc", bus.target_pc[0].pc, 32'h200);
    for (int i = 1; i < N; i++) begin
      check($sformatf("trained slot%0d valid", i), 32'(bus.target_pc[i].valid), 32'd0);
      check($sformatf("trained slot%0d pc", i), bus.target_pc[i].pc, 32'h200 + 32'(4 * i));
    end

    // Saturation holds at 11, a single not-taken drops to 10.
    retire1(32'h100, 1'b1, 32'h200);
    check("model sat hold", 32'(m_lpht[15]), 32'd3);
    retire1(32'h100, 1'b0, 32'h200);
    check("model sat dec", 32'(m_lpht[15]), 32'd2);

    // Alternating pattern at 0x344: local history captures it.
    for (int k = 0; k < 16; k++) begin
      retire1(32'h344, (k % 2) == 0, 32'h400);
    end
    check("model chooser local 0x344", 32'(m_chs[209] >= 2), 32'd1);
    idle(32'h344);
    cycle();

    // Two fired bundles, then squash with one taken retire: spec history repaired.
    idle(32'h100);
    bus.fetch_fire = 1'b1;
    cycle();
    cycle();
    pre = m_commit_ghr;
    bus.squash = 1'b1;
    bus.rob_if_packet[0] = '{valid: 1'b1, pc: 32'h344, taken: 1'b1, target: 32'h400};
    cycle();
    check("model squash ghr", 32'(m_spec_ghr), 32'(((pre << 1) | 1) % 64));
    idle(32'h100);
    cycle();

    // Reset with a retire in flight: the retire is dropped, everything returns to reset.
    idle(32'h100);
    reset = 1'b1;
    bus.rob_if_packet[0] = '{valid: 1'b1, pc: 32'h100, taken: 1'b1, target: 32'h200};
    cycle();
    idle(32'h100);
    #1;
    check_fallthrough("midreset");
    check("model midreset lpht[15]", 32'(m_lpht[15]), 32'd1);

    // Random traffic over a small PC window to provoke aliasing and chained updates.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 599) == 0);
      bus.pc_start   = 32'h100 + 32'(4 * $urandom_range(0, 63));
      bus.fetch_fire = $urandom_range(0, 1) == 1;
      bus.squash     = $urandom_range(0, 9) == 0;
      for (int i = 0; i < N; i++) begin
        bus.rob_if_packet[i].valid  = $urandom_range(0, 1) == 1;
        bus.rob_if_packet[i].pc     = 32'h100 + 32'(4 * $urandom_range(0, 63));
        bus.rob_if_packet[i].taken  = $urandom_range(0, 3) != 0;
        bus.rob_if_packet[i].target = 32'h100 + 32'(4 * $urandom_range(0, 63));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
